// File: rtl/ldtu_framer.sv
// LDTU framer: packs 32-bit words into frames closed by a CRC-12 trailer word,
// with a first-word-fall-through output FIFO and a pass-through fallback mode.
module ldtu_framer #(
    parameter int          FRAME_LEN  = 50,
    parameter int          FIFO_DEPTH = 4,
    parameter int          TIMEOUT    = 0,
    parameter logic [11:0] CRC_POLY   = 12'h80F
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        fallback_i,
    input  logic        in_valid_i,
    input  logic [31:0] in_data_i,
    input  logic        fb_valid_i,
    input  logic [31:0] fb_data_i,
    input  logic        out_ready_i,
    output logic        out_valid_o,
    output logic [31:0] out_data_o,
    output logic        losing_data_o,
    output logic [15:0] lost_count_o,
    output logic [7:0]  frame_count_o
);

    localparam int          AW         = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam logic [AW:0] DepthCnt   = (AW + 1)'(FIFO_DEPTH);
    localparam logic [7:0]  FrameLen   = 8'(FRAME_LEN);
    localparam logic [15:0] TimeoutCnt = 16'(TIMEOUT);

    typedef enum logic [1:0] {IDLE, COLLECT, PEND} state_t;

    logic [31:0]   mem [FIFO_DEPTH];
    logic [AW-1:0] rdPtr_q, wrPtr_q;
    logic [AW:0]   count_q;
    state_t        state_q;
    logic [7:0]    samples_q, wordCnt_q, frameCnt_q;
    logic [11:0]   crc_q;
    logic [15:0]   idle_q, lost_q;
    logic          losing_q;

    logic        wordSeen, pop, room, trailerPush, push, accept, drop;
    logic [31:0] wordData, pushData, trailerWord;
    logic [7:0]  wordNext;

    function automatic logic [11:0] crcStep(input logic [11:0] crc, input logic [31:0] data);
        logic [11:0] c;
        logic        fb;
        c = crc;
        for (int i = 31; i >= 0; i--) begin
            fb = c[11] ^ data[i];
            c  = {c[10:0], 1'b0} ^ (fb ? CRC_POLY : 12'h000);
        end
        return c;
    endfunction

    function automatic logic [7:0] sampleInc(input logic [7:0] d);
        if (d[7:6] == 2'b01)        return 8'd5;
        else if (d[7:6] == 2'b10)   return {2'b00, d[5:0]};
        else if (d[7:2] == 6'b001010) return 8'd2;
        else if (d[7:6] == 2'b00)   return 8'd1;
        else                        return 8'd0;
    endfunction

    // A trailer only claims the FIFO write port in a cycle with no incoming word.
    assign wordSeen    = in_valid_i | fb_valid_i;
    assign wordData    = fallback_i ? fb_data_i : in_data_i;
    assign pop         = (count_q != '0) && out_ready_i;
    assign room        = (count_q != DepthCnt) || pop;
    assign trailerPush = !fallback_i && (state_q == PEND) && !wordSeen && room;
    assign accept      = wordSeen && room && !fallback_i;
    assign drop        = wordSeen && !room;
    assign push        = (wordSeen && room) || trailerPush;
    assign trailerWord = {4'b1101, samples_q, crc_q, frameCnt_q};
    assign pushData    = trailerPush ? trailerWord : wordData;
    assign wordNext    = (wordCnt_q == 8'hFF) ? 8'hFF : wordCnt_q + 8'd1;

    always_ff @(posedge clk_i) begin
        if (push) mem[wrPtr_q] <= pushData;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rdPtr_q <= '0;
            wrPtr_q <= '0;
            count_q <= '0;
        end else begin
            if (push) wrPtr_q <= wrPtr_q + 1'b1;
            if (pop)  rdPtr_q <= rdPtr_q + 1'b1;
            unique case ({push, pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

    // Drop accounting survives fallback; only reset clears it.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= IDLE;
            samples_q  <= '0;
            wordCnt_q  <= '0;
            frameCnt_q <= '0;
            crc_q      <= '0;
            idle_q     <= '0;
            lost_q     <= '0;
            losing_q   <= 1'b0;
        end else begin
            losing_q <= drop;
            if (drop && lost_q != 16'hFFFF) lost_q <= lost_q + 16'd1;

            if (fallback_i) begin
                state_q    <= IDLE;
                samples_q  <= '0;
                wordCnt_q  <= '0;
                frameCnt_q <= '0;
                crc_q      <= '0;
                idle_q     <= '0;
            end else if (trailerPush) begin
                state_q    <= IDLE;
                samples_q  <= '0;
                wordCnt_q  <= '0;
                frameCnt_q <= frameCnt_q + 8'd1;
                crc_q      <= '0;
                idle_q     <= '0;
            end else if (accept) begin
                samples_q <= samples_q + sampleInc(wordData[31:24]);
                crc_q     <= crcStep(crc_q, wordData);
                wordCnt_q <= wordNext;
                idle_q    <= '0;
                if (state_q != PEND) state_q <= (wordNext >= FrameLen) ? PEND : COLLECT;
            end else if (wordSeen) begin
                idle_q <= '0;
            end else if (state_q == COLLECT && TimeoutCnt != 16'd0) begin
                idle_q <= idle_q + 16'd1;
                if (idle_q + 16'd1 == TimeoutCnt) state_q <= PEND;
            end
        end
    end

    assign out_valid_o   = (count_q != '0);
    assign out_data_o    = out_valid_o ? mem[rdPtr_q] : 32'hF000_0000;
    assign losing_data_o = losing_q;
    assign lost_count_o  = lost_q;
    assign frame_count_o = frameCnt_q;

endmodule

// File: tb/tb_ldtu_framer.sv
// Testbench for ldtu_framer: queue-based reference model compared every cycle,
// plus directed frame scenarios with hand-computed trailer fields.
module tb_ldtu_framer;

    localparam int          FRAME_LEN  = 50;
    localparam int          FIFO_DEPTH = 4;
    localparam int          TIMEOUT    = 16;
    localparam logic [11:0] CRC_POLY   = 12'h80F;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        fallback, in_valid, fb_valid, out_ready;
    logic [31:0] in_data, fb_data;
    logic        out_valid, losing_data;
    logic [31:0] out_data;
    logic [15:0] lost_count;
    logic [7:0]  frame_count;

    int checks   = 0;
    int failures = 0;
    int pulses   = 0;

    logic [31:0] expQ[$];
    logic [31:0] trailerLog[$];
    int          mWords, mIdle, mLost;
    logic [7:0]  mSamples, mFrame;
    logic [11:0] mCrc;
    bit          mPending, mLosing;

    ldtu_framer #(
        .FRAME_LEN (FRAME_LEN),
        .FIFO_DEPTH(FIFO_DEPTH),
        .TIMEOUT   (TIMEOUT),
        .CRC_POLY  (CRC_POLY)
    ) dut (
        .clk_i        (clk),
        .rst_ni       (rst_n),
        .fallback_i   (fallback),
        .in_valid_i   (in_valid),
        .in_data_i    (in_data),
        .fb_valid_i   (fb_valid),
        .fb_data_i    (fb_data),
        .out_ready_i  (out_ready),
        .out_valid_o  (out_valid),
        .out_data_o   (out_data),
        .losing_data_o(losing_data),
        .lost_count_o (lost_count),
        .frame_count_o(frame_count)
    );

    always #5 clk = ~clk;

    // Sample increment from the word's top byte, by value range.
    function automatic int incOf(input logic [7:0] d);
        int v;
        v = int'(d);
        if (v >= 64 && v < 128)  return 5;
        if (v >= 128 && v < 192) return v - 128;
        if (v >= 40 && v < 44)   return 2;
        if (v < 64)              return 1;
        return 0;
    endfunction

    // CRC as the remainder of (crc*x^32 + data*x^12) modulo the generator.
    function automatic logic [11:0] crcOf(input logic [11:0] c, input logic [31:0] d);
        logic [43:0] v;
        logic [12:0] g;
        g = {1'b1, CRC_POLY};
        v = {c, 32'd0} ^ {d, 12'd0};
        for (int i = 43; i >= 12; i--)
            if (v[i]) v = v ^ ({31'd0, g} << (i - 12));
        return v[11:0];
    endfunction

    // Reference model: FIFO as a queue, frame bookkeeping as plain counters.
    always @(posedge clk or negedge rst_n) begin : model
        logic [31:0] d, t;
        bit          word, room, pop;
        if (!rst_n) begin
            expQ.delete();
            mWords = 0; mIdle = 0; mLost = 0; mSamples = 0; mFrame = 0;
            mCrc = 0; mPending = 0; mLosing = 0;
        end else begin
            pop  = (expQ.size() != 0) && out_ready;
            room = (expQ.size() < FIFO_DEPTH) || pop;
            word = in_valid || fb_valid;
            d    = fallback ? fb_data : in_data;
            if (pop) void'(expQ.pop_front());
            mLosing = 0;
            if (word) begin
                if (room) expQ.push_back(d);
                else begin
                    mLosing = 1;
                    if (mLost < 65535) mLost++;
                end
            end
            if (fallback) begin
                mWords = 0; mIdle = 0; mSamples = 0; mCrc = 0; mFrame = 0; mPending = 0;
            end else if (word) begin
                mIdle = 0;
                if (room) begin
                    mSamples = mSamples + 8'(incOf(d[31:24]));
                    mCrc     = crcOf(mCrc, d);
                    if (mWords < 255) mWords++;
                    if (mWords >= FRAME_LEN) mPending = 1;
                end
            end else if (mPending) begin
                if (room) begin
                    t = {4'hD, mSamples, mCrc, mFrame};
                    expQ.push_back(t);
                    trailerLog.push_back(t);
                    mFrame = mFrame + 8'd1;
                    mWords = 0; mIdle = 0; mSamples = 0; mCrc = 0; mPending = 0;
                end
            end else if (mWords > 0) begin
                mIdle++;
                if (TIMEOUT > 0 && mIdle == TIMEOUT) mPending = 1;
            end
        end
    end

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s actual=%h expected=%h at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic compareLoop();
        forever begin
            @(posedge clk);
            #2;
            checkOutput("out_valid", {31'd0, out_valid}, {31'd0, expQ.size() != 0});
            checkOutput("out_data", out_data, (expQ.size() != 0) ? expQ[0] : 32'hF000_0000);
            checkOutput("losing_data", {31'd0, losing_data}, {31'd0, mLosing});
            checkOutput("lost_count", {16'd0, lost_count}, 32'(mLost));
            checkOutput("frame_count", {24'd0, frame_count}, {24'd0, mFrame});
            if (losing_data) pulses++;
        end
    endtask

    task automatic applyStimulus(input logic inV, input logic [31:0] inD, input logic fbV,
                                 input logic [31:0] fbD, input logic fb);
        @(negedge clk);
        in_valid = inV; in_data = inD; fb_valid = fbV; fb_data = fbD; fallback = fb;
    endtask

    task automatic sendWords(input int n, input logic [31:0] d);
        for (int i = 0; i < n; i++) applyStimulus(1'b1, d, 1'b0, 32'd0, 1'b0);
    endtask

    task automatic idleCycles(input int n, input logic fb);
        for (int i = 0; i < n; i++) applyStimulus(1'b0, 32'd0, 1'b0, 32'd0, fb);
    endtask

    task automatic checkTrailer(input string name, input int count, input logic [7:0] samples,
                                input logic [7:0] frameNo);
        logic [31:0] t;
        checkOutput({name, "_trailer_count"}, 32'(trailerLog.size()), 32'(count));
        t = (trailerLog.size() != 0) ? trailerLog[trailerLog.size() - 1] : 32'd0;
        checkOutput({name, "_trailer_head"}, {28'd0, t[31:28]}, 32'hD);
        checkOutput({name, "_trailer_samples"}, {24'd0, t[27:20]}, {24'd0, samples});
        checkOutput({name, "_trailer_frame"}, {24'd0, t[7:0]}, {24'd0, frameNo});
    endtask

    initial begin
        int base;
        rst_n = 1'b0; fallback = 1'b0; in_valid = 1'b0; fb_valid = 1'b0;
        in_data = '0; fb_data = '0; out_ready = 1'b1;
        fork
            compareLoop();
        join_none
        idleCycles(3, 1'b0);
        checkOutput("reset_out_valid", {31'd0, out_valid}, 32'd0);
        checkOutput("reset_out_data", out_data, 32'hF000_0000);
        checkOutput("reset_frame_count", {24'd0, frame_count}, 32'd0);
        rst_n = 1'b1;

        // Fill the FIFO with the consumer stalled, then reset mid-frame.
        out_ready = 1'b0;
        base = pulses;
        sendWords(6, 32'h4000_0000);
        idleCycles(2, 1'b0);
        checkOutput("prereset_lost_count", {16'd0, lost_count}, 32'd2);
        checkOutput("prereset_pulses", 32'(pulses - base), 32'd2);
        rst_n = 1'b0;
        #1;
        checkOutput("reset_now_out_valid", {31'd0, out_valid}, 32'd0);
        checkOutput("reset_now_out_data", out_data, 32'hF000_0000);
        checkOutput("reset_now_lost_count", {16'd0, lost_count}, 32'd0);
        idleCycles(2, 1'b0);
        rst_n = 1'b1;
        out_ready = 1'b1;

        // Two full frames of 50 words, 5 samples each.
        sendWords(50, 32'h4000_0000);
        idleCycles(4, 1'b0);
        checkTrailer("frame0", 1, 8'hFA, 8'h00);
        checkOutput("frame0_count", {24'd0, frame_count}, 32'd1);
        sendWords(50, 32'h4000_0000);
        idleCycles(4, 1'b0);
        checkTrailer("frame1", 2, 8'hFA, 8'h01);

        // Overflow: 4 words stored, 2 dropped; trailer waits for FIFO space.
        out_ready = 1'b0;
        base = pulses;
        sendWords(6, 32'h2800_0000);
        idleCycles(30, 1'b0);
        checkOutput("ovf_lost_count", {16'd0, lost_count}, 32'd2);
        checkOutput("ovf_pulses", 32'(pulses - base), 32'd2);
        checkOutput("ovf_frame_held", {24'd0, frame_count}, 32'd2);
        out_ready = 1'b1;
        idleCycles(8, 1'b0);
        checkTrailer("ovf", 3, 8'h08, 8'h02);

        // Timeout closes a 3-word partial frame.
        sendWords(3, 32'h2800_0000);
        idleCycles(8, 1'b0);
        checkOutput("timeout_not_yet", {24'd0, frame_count}, 32'd3);
        idleCycles(17, 1'b0);
        checkOutput("timeout_closed", {24'd0, frame_count}, 32'd4);
        checkTrailer("timeout", 4, 8'h06, 8'h03);

        // 60 back-to-back words: trailer waits for the first idle cycle.
        sendWords(60, 32'h8300_0000);
        idleCycles(1, 1'b0);
        checkOutput("long_no_trailer", {24'd0, frame_count}, 32'd4);
        idleCycles(3, 1'b0);
        checkTrailer("long", 5, 8'hB4, 8'h04);

        // Fallback mid-frame discards the frame and passes fb words through.
        sendWords(10, 32'h4000_0000);
        for (int i = 0; i < 5; i++) applyStimulus(1'b0, 32'd0, 1'b1, 32'hD5A5_0000 + 32'(i * 7), 1'b1);
        idleCycles(2, 1'b1);
        checkOutput("fallback_frame_count", {24'd0, frame_count}, 32'd0);
        checkOutput("fallback_no_trailer", 32'(trailerLog.size()), 32'd5);
        idleCycles(1, 1'b0);
        sendWords(50, 32'h2800_0000);
        idleCycles(4, 1'b0);
        checkTrailer("after_fb", 6, 8'h64, 8'h00);

        idleCycles(2, 1'b0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
